// File: rtl/midi_parser_pkg.sv
// Shared constants, types and the byte classifier for the MIDI channel-voice parser.
// Optional build macro: MIDI_OMNI_EN (accept all 16 channels).
package midi_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned STATE_W = 2;

  localparam logic [3:0] OP_NOTE_OFF = 4'h8;
  localparam logic [3:0] OP_NOTE_ON  = 4'h9;
  localparam logic [3:0] OP_CC       = 4'hB;
  localparam logic [3:0] OP_PROG     = 4'hC;
  localparam logic [3:0] OP_CHAN_AT  = 4'hD;
  localparam logic [DATA_W-1:0] CC_ALL_OFF = 7'h7B;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_D1 = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_D2 = 2'd2;

  typedef enum logic [1:0] {
    BC_DATA,
    BC_CHANNEL,
    BC_SYSTEM,
    BC_REALTIME
  } byte_class_e;

  typedef struct packed {
    logic              on;
    logic [DATA_W-1:0] num;
    logic [DATA_W-1:0] vel;
  } note_evt_t;

  // Real-time bytes (F8..FF) must be recognised before the generic Fx system class.
  function automatic byte_class_e classify(input logic [BYTE_W-1:0] b);
    byte_class_e c;
    if (!b[7])                c = BC_DATA;
    else if (b >= 8'hF8)      c = BC_REALTIME;
    else if (b[7:4] == 4'hF)  c = BC_SYSTEM;
    else                      c = BC_CHANNEL;
    return c;
  endfunction

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op != OP_PROG) && (op != OP_CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI channel-voice parser: running status, transparent real-time bytes, registered note/all-off events.
// Build option: define MIDI_OMNI_EN to accept messages on every channel.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter int unsigned MIDI_CHANNEL = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BYTE_W-1:0] rxData_i,
  input  logic              rxValid_i,
  output logic              noteValid_o,
  output logic              noteOn_o,
  output logic [DATA_W-1:0] noteNum_o,
  output logic [DATA_W-1:0] velocity_o,
  output logic              allOff_o
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [BYTE_W-1:0]  run_status, run_status_nxt;
  logic [DATA_W-1:0]  d1, d1_nxt;
  logic               chan_ok;
  byte_class_e        bclass;
  logic               ev_note, ev_all;
  note_evt_t          ev;
  note_evt_t          evt_q;

  assign bclass = classify(rxData_i);

`ifdef MIDI_OMNI_EN
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (run_status[3:0] == 4'(MIDI_CHANNEL));
`endif

  // State and message context registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      run_status <= '0;
      d1         <= '0;
    end else begin
      state      <= state_nxt;
      run_status <= run_status_nxt;
      d1         <= d1_nxt;
    end
  end

  // Next-state and event decode
  always_comb begin
    state_nxt      = state;
    run_status_nxt = run_status;
    d1_nxt         = d1;
    ev_note        = 1'b0;
    ev_all         = 1'b0;
    ev             = '0;
    if (rxValid_i) begin
      case (bclass)
        BC_REALTIME: ;
        BC_SYSTEM: begin
          run_status_nxt = '0;
          state_nxt      = ST_IDLE;
        end
        BC_CHANNEL: begin
          run_status_nxt = rxData_i;
          state_nxt      = ST_WAIT_D1;
        end
        default: begin
          case (state)
            ST_WAIT_D1: begin
              if (is_two_byte(run_status[7:4])) begin
                d1_nxt    = rxData_i[DATA_W-1:0];
                state_nxt = ST_WAIT_D2;
              end
            end
            ST_WAIT_D2: begin
              state_nxt = ST_WAIT_D1;
              if (chan_ok) begin
                case (run_status[7:4])
                  OP_NOTE_OFF: begin
                    ev_note = 1'b1;
                    ev.num  = d1;
                  end
                  OP_NOTE_ON: begin
                    ev_note = 1'b1;
                    ev.num  = d1;
                    ev.on   = (rxData_i[DATA_W-1:0] != '0);
                    ev.vel  = rxData_i[DATA_W-1:0];
                  end
                  OP_CC: ev_all = (d1 == CC_ALL_OFF);
                  default: ;
                endcase
              end
            end
            ST_IDLE: ;
            default: state_nxt = ST_IDLE;
          endcase
        end
      endcase
    end
  end

  // Registered outputs: strobes for one cycle, event payload held until the next event
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      noteValid_o <= 1'b0;
      allOff_o    <= 1'b0;
      evt_q       <= '0;
    end else begin
      noteValid_o <= ev_note;
      allOff_o    <= ev_all;
      if (ev_note) evt_q <= ev;
    end
  end

  assign noteOn_o   = evt_q.on;
  assign noteNum_o  = evt_q.num;
  assign velocity_o = evt_q.vel;

endmodule
